// File: rtl/icache_pkg.sv
// Shared state encoding and address-width helpers for the set-associative instruction cache.
package icache_pkg;

    localparam int unsigned WORD_BITS = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitMem = 2'd1,
        StDrain   = 2'd2
    } state_e;

    // Word-aligned 32-bit address: 30 bits remain once the byte offset is dropped.
    function automatic int unsigned tag_width(input int unsigned set_w,
                                              input int unsigned block_w);
        return 30 - set_w - block_w;
    endfunction

    function automatic int unsigned index_width(input int unsigned set_w);
        return set_w;
    endfunction

    function automatic int unsigned offset_width(input int unsigned block_w);
        return block_w;
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// Per-way tag/valid/data storage with a parallel tag compare across all ways of one set.
module icache_way_array
    import icache_pkg::*;
#(
    parameter int unsigned WAYS        = 2,
    parameter int unsigned SET_WIDTH   = 2,
    parameter int unsigned BLOCK_WIDTH = 2,
    parameter int unsigned TAG_WIDTH   = 26
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  flush_i,
    input  logic [SET_WIDTH-1:0]                  lookup_index_i,
    input  logic [TAG_WIDTH-1:0]                  lookup_tag_i,
    input  logic [BLOCK_WIDTH-1:0]                lookup_offset_i,
    output logic [WAYS-1:0]                       hit_vec_o,
    output logic [WORD_BITS-1:0]                  hit_word_o,
    input  logic [WAYS-1:0]                       wr_way_i,
    input  logic [SET_WIDTH-1:0]                  wr_index_i,
    input  logic [TAG_WIDTH-1:0]                  wr_tag_i,
    input  logic [WORD_BITS*(1<<BLOCK_WIDTH)-1:0] wr_block_i
);

    localparam int unsigned SETS       = 1 << SET_WIDTH;
    localparam int unsigned BLOCK_BITS = WORD_BITS << BLOCK_WIDTH;

    logic [SETS-1:0]       valid_q [WAYS];
    logic [TAG_WIDTH-1:0]  tag_q   [WAYS][SETS];
    logic [BLOCK_BITS-1:0] data_q  [WAYS][SETS];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (wr_way_i[w]) begin
                    valid_q[w][wr_index_i] <= 1'b1;
                end
            end
        end
    end

    // Tag and data contents are meaningless until their valid bit is set, so no reset.
    always_ff @(posedge clk_in) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (wr_way_i[w]) begin
                tag_q[w][wr_index_i]  <= wr_tag_i;
                data_q[w][wr_index_i] <= wr_block_i;
            end
        end
    end

    // At most one way can match, so OR-ing the selected words is a safe mux.
    always_comb begin
        hit_vec_o  = '0;
        hit_word_o = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][lookup_index_i] && (tag_q[w][lookup_index_i] == lookup_tag_i)) begin
                hit_vec_o[w] = 1'b1;
                hit_word_o   = hit_word_o |
                               data_q[w][lookup_index_i][{lookup_offset_i, 5'b0} +: WORD_BITS];
            end
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache between IF and the memory controller, round-robin refill.
// Define ICACHE_PERF_CNT_EN to add saturating hit/miss counters (perf_hit_cnt, perf_miss_cnt).
module icache_sa
    import icache_pkg::*;
#(
    parameter int unsigned WAY_WIDTH   = 1,
    parameter int unsigned SET_WIDTH   = 2,
    parameter int unsigned BLOCK_WIDTH = 2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  rdy_in,
    input  logic                                  flush_in,
    input  logic                                  clear_in,
    input  logic                                  IF_query_en,
    input  logic [31:0]                           IF_query_addr,
    output logic                                  IF_query_ready,
    output logic                                  IF_data_out_en,
    output logic [31:0]                           IF_data_out,
    output logic                                  MC_query_en,
    output logic [31:0]                           MC_query_addr,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]                           perf_hit_cnt,
    output logic [31:0]                           perf_miss_cnt,
`endif
    input  logic                                  MC_data_en,
    input  logic [WORD_BITS*(1<<BLOCK_WIDTH)-1:0] MC_data
);

    localparam int unsigned WAYS      = 1 << WAY_WIDTH;
    localparam int unsigned SETS      = 1 << SET_WIDTH;
    localparam int unsigned IDX_W     = index_width(SET_WIDTH);
    localparam int unsigned OFF_W     = offset_width(BLOCK_WIDTH);
    localparam int unsigned TAG_WIDTH = tag_width(SET_WIDTH, BLOCK_WIDTH);

    logic [TAG_WIDTH-1:0] req_tag;
    logic [IDX_W-1:0]     req_index;
    logic [OFF_W-1:0]     req_offset;
    logic [1:0]           unused_byte_bits;

    assign req_tag          = IF_query_addr[31 -: TAG_WIDTH];
    assign req_index        = IF_query_addr[OFF_W+2 +: IDX_W];
    assign req_offset       = IF_query_addr[2 +: OFF_W];
    assign unused_byte_bits = IF_query_addr[1:0];

    state_e               state_q, state_d;
    logic                 discard_q, discard_d;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [IDX_W-1:0]     index_q;
    logic [OFF_W-1:0]     offset_q;
    logic [WAY_WIDTH-1:0] rr_ptr_q [SETS];

    logic                 data_en_q, data_en_d;
    logic [31:0]          data_q, data_d;
    logic                 mc_en_q, mc_en_d;
    logic [31:0]          mc_addr_q, mc_addr_d;

    logic [WAYS-1:0]      hit_vec;
    logic [WAYS-1:0]      wr_way;
    logic [31:0]          hit_word;
    logic                 hit;
    logic                 accept;
    logic                 refill_write;
    logic                 refill_respond;

    assign IF_query_ready = (state_q == StIdle) && !flush_in;
    // A same-cycle clear cancels the request before it can schedule a response.
    assign accept         = rdy_in && IF_query_en && IF_query_ready && !clear_in;
    assign hit            = |hit_vec;

    assign IF_data_out_en = data_en_q;
    assign IF_data_out    = data_q;
    assign MC_query_en    = mc_en_q;
    assign MC_query_addr  = mc_addr_q;

    icache_way_array #(
        .WAYS        (WAYS),
        .SET_WIDTH   (SET_WIDTH),
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_way_array (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .flush_i         (rdy_in && flush_in),
        .lookup_index_i  (req_index),
        .lookup_tag_i    (req_tag),
        .lookup_offset_i (req_offset),
        .hit_vec_o       (hit_vec),
        .hit_word_o      (hit_word),
        .wr_way_i        (wr_way),
        .wr_index_i      (index_q),
        .wr_tag_i        (tag_q),
        .wr_block_i      (MC_data)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // discard_q remembers whether the block in flight must be dropped (flush) or kept (clear).
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        case (state_q)
            StIdle: begin
                if (accept && !hit) begin
                    state_d   = StWaitMem;
                    discard_d = 1'b0;
                end
            end
            StWaitMem: begin
                if (flush_in) begin
                    state_d   = MC_data_en ? StIdle : StDrain;
                    discard_d = 1'b1;
                end else if (MC_data_en) begin
                    state_d = StIdle;
                end else if (clear_in) begin
                    state_d   = StDrain;
                    discard_d = 1'b0;
                end
            end
            StDrain: begin
                if (flush_in) begin
                    discard_d = 1'b1;
                end
                if (MC_data_en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_en_d      = 1'b0;
        data_d         = data_q;
        mc_en_d        = mc_en_q;
        mc_addr_d      = mc_addr_q;
        refill_write   = 1'b0;
        refill_respond = 1'b0;
        wr_way         = '0;
        case (state_q)
            StIdle: begin
                if (accept && hit) begin
                    data_en_d = 1'b1;
                    data_d    = hit_word;
                end else if (accept) begin
                    mc_en_d   = 1'b1;
                    mc_addr_d = {req_tag, req_index, {(OFF_W + 2){1'b0}}};
                end
            end
            StWaitMem: begin
                if (MC_data_en) begin
                    mc_en_d        = 1'b0;
                    refill_write   = !flush_in;
                    refill_respond = !flush_in && !clear_in;
                end
            end
            StDrain: begin
                if (MC_data_en) begin
                    mc_en_d      = 1'b0;
                    refill_write = !flush_in && !discard_q;
                end
            end
            default: ;
        endcase
        if (refill_respond) begin
            data_en_d = 1'b1;
            data_d    = MC_data[{offset_q, 5'b0} +: WORD_BITS];
        end
        if (rdy_in && refill_write) begin
            wr_way[rr_ptr_q[index_q]] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_en_q <= 1'b0;
            data_q    <= '0;
            mc_en_q   <= 1'b0;
            mc_addr_q <= '0;
            tag_q     <= '0;
            index_q   <= '0;
            offset_q  <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_ptr_q[s] <= '0;
            end
        end else if (rdy_in) begin
            data_en_q <= data_en_d;
            data_q    <= data_d;
            mc_en_q   <= mc_en_d;
            mc_addr_q <= mc_addr_d;
            if (accept && !hit) begin
                tag_q    <= req_tag;
                index_q  <= req_index;
                offset_q <= req_offset;
            end
            if (flush_in) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    rr_ptr_q[s] <= '0;
                end
            end else if (refill_write) begin
                rr_ptr_q[index_q] <= rr_ptr_q[index_q] + WAY_WIDTH'(1);
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_cnt_q != '1) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end else if (miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache between the IF stage and the memory controller (MC).
- Generalises the direct-mapped ICache with:
  - configurable associativity, set count and block size;
  - round-robin replacement per set;
  - full-cache flush;
  - IF-side cancel on redirect.
- One request outstanding at a time. A hit returns data in 1 cycle; a miss refills one whole block from MC.

Parameters:
- WAY_WIDTH, 1, log2 of ways; WAYS = 1<<WAY_WIDTH, so 1 gives 2-way.
- SET_WIDTH, 2, log2 of sets; SETS = 1<<SET_WIDTH.
- BLOCK_WIDTH, 2, log2 of 32-bit words per block; BLOCK_SIZE = 1<<BLOCK_WIDTH.
- TAG_WIDTH, 30-SET_WIDTH-BLOCK_WIDTH, derived, not to be overridden.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global enable; 0 freezes every register
- flush_in  in  1  invalidate all lines
- clear_in  in  1  IF redirect; cancel pending response
- IF_query_en  in  1  fetch request, valid only when IF_query_ready=1
- IF_query_addr  in  32  byte address; bits [1:0] ignored
- IF_query_ready  out  1  1 in IDLE with flush_in=0
- IF_data_out_en  out  1  one-cycle response pulse
- IF_data_out  out  32  instruction word
- MC_query_en  out  1  held high until MC_data_en
- MC_query_addr  out  32  block-aligned address {tag,index,BLOCK_WIDTH+2 zeros}
- MC_data_en  in  1  refill data valid, one cycle
- MC_data  in  32*BLOCK_SIZE  block; word k at bits [32k+31:32k]

Behaviour:
- Address split:
  - offset = addr[BLOCK_WIDTH+1:2]
  - index = addr[SET_WIDTH+BLOCK_WIDTH+1:BLOCK_WIDTH+2]
  - tag = addr[31:SET_WIDTH+BLOCK_WIDTH+2]
- Reset (async): all valid bits 0; all RR pointers 0; state IDLE; IF_data_out_en=0; IF_data_out=0; MC_query_en=0; MC_query_addr=0. Data/tag arrays are not reset.
- rdy_in=0: no state, array or output register changes; outputs hold.
- States: IDLE, WAIT_MEM, DRAIN.
- IDLE, request accepted (IF_query_en & IF_query_ready):
  - Hit (any valid way whose tag matches): next cycle IF_data_out_en=1 and IF_data_out=word[offset]; stay IDLE; pointer unchanged.
  - Miss: next cycle MC_query_en=1 with MC_query_addr set, latch tag/index/offset, go to WAIT_MEM.
- Hits never match two ways; the refill rule guarantees it.
- WAIT_MEM on MC_data_en:
  - Write block and tag into victim = rr_ptr[index]; set valid; rr_ptr[index] += 1 (wraps mod WAYS).
  - Next cycle: MC_query_en=0, IF_data_out_en=1, IF_data_out=MC_data word[offset]; go to IDLE.
- Victim choice: round-robin only. Invalid ways are not preferred.
- clear_in in WAIT_MEM: go to DRAIN. On MC_data_en the refill still completes into the array, but no IF response; then go to IDLE.
- clear_in in IDLE: suppresses the response scheduled for the next cycle. A same-cycle request is ignored.
- flush_in:
  - All valid bits cleared in the cycle it is sampled; rr pointers reset to 0.
  - In WAIT_MEM or DRAIN: go to DRAIN; the returning block is discarded (not written) and no response is given.
  - Flush has priority over a same-cycle MC_data_en: data discarded, state IDLE.
- IF_data_out_en is a single-cycle pulse; IF_data_out holds its last value otherwise.
- MC_query_en drops the cycle after MC_data_en and never re-asserts in the same cycle.

Optional Feature:
- ICACHE_PERF_CNT_EN defined: adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - Each counts accepted requests (miss counted on entering WAIT_MEM).
  - Saturates at 0xFFFFFFFF; cleared by reset, not by flush.
- Not defined: the ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Package icache_pkg:
  - state encoding localparams (IDLE=0, WAIT_MEM=1, DRAIN=2);
  - width-derivation functions for tag, index and offset.
- One natural sub-module, icache_way_array:
  - per-way tag/valid/data storage with a parallel tag compare;
  - outputs hit vector and hit word;
  - instantiated once, parametrised by WAYS.

Test Plan:
- Cold miss at 0x104 (default params): MC_query_addr=0x100 the next cycle. Return block {0xD,0xC,0xB,0xA} (word0=0xA). Expect IF_data_out=0xB, then query 0x108 hits with 0xC in 1 cycle and no MC activity.
- Conflict/RR at index 0: fill 0x000 (way0), then 0x040 (way1). 0x000 hits. 0x080 refills way0, evicting 0x000. 0x040 still hits; 0x000 misses.
- Flush in WAIT_MEM for 0x200: MC returns the block with no IF pulse. Re-query 0x200 misses and re-issues MC_query_addr=0x200.
- clear_in in WAIT_MEM for 0x300: no IF pulse. Next query 0x304 hits, proving the block was written.
- rdy_in=0 for 5 cycles mid-WAIT_MEM, with MC_data_en withheld during that window: all outputs frozen. Refill completes normally after rdy_in returns to 1.
- Async reset asserted between clock edges during WAIT_MEM: MC_query_en=0 immediately. Query 0x104 after reset misses, since all lines are invalid.
